mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory sequencer; consumes the 2-bit byte-enable produced by the MEM-stage enable decoder.
//  Turns one LC-3b memory instruction (LDR/LDB/LDI/STR/STB/STI) into 1 or 2 dcache transactions.
//  Stalls the pipeline until the last transaction completes, then returns the load data.
//  Sits between the MEM pipeline register and the dcache port.
// PARAMETERS
//  ADDR_W      16  address width
//  DATA_W      16  data width
//  PERF_CNT_W  32  width of perf counters (used only with MEM_ACCESS_PERF_EN)
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous active-high reset
//  req_valid    in   1       MEM stage holds a valid instruction
//  opcode       in   4       lc3b_opcode of that instruction
//  addr         in   ADDR_W  effective address from EX
//  wdata        in   DATA_W  store data (already byte-aligned for STB)
//  byte_en      in   2       byte-enable from the enable decoder
//  dmem_resp    in   1       dcache transaction complete (1-cycle pulse)
//  dmem_rdata   in   DATA_W  dcache read data, valid with dmem_resp
//  dmem_read    out  1       dcache read strobe
//  dmem_write   out  1       dcache write strobe
//  dmem_addr    out  ADDR_W  dcache address
//  dmem_wdata   out  DATA_W  dcache write data
//  dmem_byte_en out  2       dcache byte-write mask
//  stall_out    out  1       freeze upstream pipeline
//  done         out  1       instruction finished this cycle
//  mem_rdata    out  DATA_W  final load data, valid while done=1
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; internal addr/data registers 0.
//  States: IDLE, ACC1, ACC2, DONE.
//  IDLE: accept if req_valid && opcode in {LDR,LDB,LDI,STR,STB,STI}; latch addr/wdata/byte_en/opcode -> ACC1.
//    Any other opcode, or req_valid=0: stay IDLE, no dcache activity; stall_out=0.
//  ACC1: dmem_addr = latched addr.
//    LDR/LDB/LDI/STI: dmem_read=1.  STR/STB: dmem_write=1, dmem_byte_en = latched byte_en.
//    On dmem_resp: LDI/STI -> capture dmem_rdata as pointer -> ACC2; others -> capture rdata -> DONE.
//  ACC2: dmem_addr = pointer. LDI: dmem_read=1. STI: dmem_write=1, dmem_byte_en=2'b11.
//    On dmem_resp -> capture rdata -> DONE.
//  DONE: done=1, mem_rdata = captured word (whole word; byte select is downstream) -> IDLE.
//  Strobes/address/data are registered from state; held stable until dmem_resp.
//  dmem_read and dmem_write are never both 1. dmem_byte_en = 2'b00 on reads and in IDLE/DONE.
//  stall_out = req_valid && accepted-op && state != DONE (combinational);
//    0 in DONE, so the pipeline advances in that cycle.
//  Latency: single access = resp_latency + 2 cycles; indirect = 2*resp_latency + 3.
//  dmem_resp while in IDLE/DONE: ignored.
//  Store with byte_en=2'b00 is still issued (mask 00), so the dcache sees no byte written.
//  Inputs may change while busy; only latched copies are used.
//  rst asserted mid-transaction: strobes drop in the same cycle; the transaction is abandoned.
// CONFIGURATION
//  MEM_ACCESS_PERF_EN defined: add ports
//    perf_stall_cnt  out  PERF_CNT_W  cycles with stall_out=1
//    perf_access_cnt out  PERF_CNT_W  dmem_resp count
//    Both are saturating, reset to 0.
//  Not defined: ports and counters are absent; no other behaviour changes.
// TESTING
//  LDR addr=0x1000, resp after 3 cycles rdata=0xBEEF -> one read @0x1000; done 1 cycle after resp;
//    mem_rdata=0xBEEF; stall 4 cycles.
//  STB addr=0x2001 byte_en=2'b10 wdata=0xAB00 -> one write @0x2001, dmem_byte_en=10, wdata=0xAB00.
//  LDI addr=0x3000, first rdata=0x4000, second rdata=0x1234 -> reads @0x3000 then @0x4000;
//    mem_rdata=0x1234.
//  STI addr=0x3000 ptr=0x5000 wdata=0x00FF -> read @0x3000, then write @0x5000 with byte_en=11.
//  ADD opcode with req_valid=1, plus a spurious dmem_resp -> no strobes, stall_out=0, done=0.
//  rst pulse during ACC2 of LDI -> all outputs 0 immediately; a following LDR completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns one LC-3b load/store (LDR/LDB/LDI/STR/STB/STI) into 1-2 dcache transactions.
// Optional saturating perf counters are compiled in when MEM_ACCESS_PERF_EN is defined.
module mem_access_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int PERF_CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        byte_en,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_en,
    output logic              stall_out,
    output logic              done,
`ifdef MEM_ACCESS_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_access_cnt,
`endif
    output logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

    state_t            r_state;
    logic [3:0]        r_opcode;
    logic              r_dmem_read;
    logic              r_dmem_write;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic [1:0]        r_dmem_byte_en;
    logic              r_done;
    logic [DATA_W-1:0] r_mem_rdata;

    logic w_is_mem_op;
    logic w_is_store;
    logic w_accept;
    logic w_stall;

    always_comb begin
        w_is_mem_op = 1'b0;
        w_is_store  = 1'b0;
        case (opcode)
            OP_LDB, OP_LDR, OP_LDI, OP_STI: w_is_mem_op = 1'b1;
            OP_STB, OP_STR: begin
                w_is_mem_op = 1'b1;
                w_is_store  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_accept = req_valid && w_is_mem_op;
    // Released in DONE so the pipeline advances on the same cycle done is shown.
    assign w_stall  = w_accept && (r_state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_opcode       <= '0;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_byte_en <= 2'b00;
            r_done         <= 1'b0;
            r_mem_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_opcode     <= opcode;
                        r_dmem_addr  <= addr;
                        r_dmem_wdata <= wdata;
                        r_state      <= S_ACC1;
                        if (w_is_store) begin
                            r_dmem_write   <= 1'b1;
                            r_dmem_byte_en <= byte_en;
                        end else begin
                            r_dmem_read <= 1'b1;
                        end
                    end
                end
                S_ACC1: begin
                    if (dmem_resp) begin
                        r_dmem_read    <= 1'b0;
                        r_dmem_write   <= 1'b0;
                        r_dmem_byte_en <= 2'b00;
                        if (r_opcode == OP_LDI || r_opcode == OP_STI) begin
                            r_dmem_addr <= dmem_rdata[ADDR_W-1:0];
                            r_state     <= S_ACC2;
                        end else begin
                            r_mem_rdata <= dmem_rdata;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ACC2: begin
                    // First ACC2 cycle is a strobe-low bubble so the dcache sees a fresh request edge.
                    if (!r_dmem_read && !r_dmem_write) begin
                        if (r_opcode == OP_STI) begin
                            r_dmem_write   <= 1'b1;
                            r_dmem_byte_en <= 2'b11;
                        end else begin
                            r_dmem_read <= 1'b1;
                        end
                    end else if (dmem_resp) begin
                        r_dmem_read    <= 1'b0;
                        r_dmem_write   <= 1'b0;
                        r_dmem_byte_en <= 2'b00;
                        r_mem_rdata    <= dmem_rdata;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_read    = r_dmem_read;
    assign dmem_write   = r_dmem_write;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign dmem_byte_en = r_dmem_byte_en;
    assign stall_out    = w_stall;
    assign done         = r_done;
    assign mem_rdata    = r_mem_rdata;

`ifdef MEM_ACCESS_PERF_EN
    logic [PERF_CNT_W-1:0] r_perf_stall;
    logic [PERF_CNT_W-1:0] r_perf_access;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall  <= '0;
            r_perf_access <= '0;
        end else begin
            if (w_stall && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + PERF_CNT_W'(1);
            if (dmem_resp && (r_perf_access != '1))
                r_perf_access <= r_perf_access + PERF_CNT_W'(1);
        end
    end

    assign perf_stall_cnt  = r_perf_stall;
    assign perf_access_cnt = r_perf_access;
`endif

endmodule
